// File: rtl/rfs_wifi_capture_pkg.sv
// Shared types and constants for the sample-memory capture path.
// Holds the FSM state encoding and the memory geometry.
package rfs_wifi_capture_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int MEM_DEPTH  = 35000;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Addresses are not bounded by the writer; this lets a host check a window up front.
  function automatic logic addr_in_mem(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < MEM_DEPTH);
  endfunction

endpackage

// File: rtl/rfs_wifi_capture_fifo.sv
// Synchronous FIFO with register storage and read-data taken straight from the head slot.
// Push is ignored when full, pop when empty; flush empties it in one cycle.
module rfs_wifi_capture_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_dat     = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/rfs_wifi_sample_capture.sv
// Streams sop/eop packets into a window of the sample memory, one-shot or circular.
// Beat accepted at edge k is written after edge k+1; snk_ready drops on FIFO full or length limit.
module rfs_wifi_sample_capture #(
  parameter int DATA_W     = rfs_wifi_capture_pkg::DATA_W,
  parameter int ADDR_W     = rfs_wifi_capture_pkg::ADDR_W,
  parameter int FIFO_DEPTH = rfs_wifi_capture_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_wrap,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_overflow,
  output logic [ADDR_W-1:0] sts_count
);

  import rfs_wifi_capture_pkg::*;

  state_t            r_state;
  state_t            w_next;
  logic              r_wrap;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_off;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_trunc;
  logic              r_ovf;
  logic              r_mem_write;
  logic              r_clken;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_push;
  logic              w_pop;
  logic              w_rdy;
  logic              w_last;
  logic              w_start;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_dat;

  // One-shot only: this push is the final word the window will take.
  assign w_last  = !r_wrap && ((r_acc + ADDR_W'(1)) == r_len);
  assign w_start = (r_state == ST_IDLE) && cfg_start && !cfg_abort;

  rfs_wifi_capture_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (cfg_abort),
    .i_push  (w_push),
    .i_dat   (snk_data),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (cfg_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (cfg_start) w_next = (cfg_len == '0) ? ST_DONE : ST_ARMED;
        ST_ARMED,
        ST_CAPTURE: begin
          if (w_push && (snk_eop || w_last)) w_next = ST_DRAIN;
          else if (w_push)                   w_next = ST_CAPTURE;
        end
        ST_DRAIN:   if (w_empty) w_next = ST_DONE;
        ST_DONE:    w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdy    = 1'b0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    sts_busy = (r_state != ST_IDLE);
    sts_done = (r_state == ST_DONE);
    case (r_state)
      ST_ARMED: begin
        w_rdy  = 1'b1;
        w_push = snk_valid && snk_sop && !cfg_abort;
      end
      ST_CAPTURE: begin
        w_rdy  = !w_full && (r_wrap || (r_acc < r_len));
        w_push = snk_valid && w_rdy && !cfg_abort;
        w_pop  = !w_empty && !cfg_abort;
      end
      ST_DRAIN: w_pop = !w_empty && !cfg_abort;
      default:  w_rdy = 1'b0;
    endcase
    snk_ready = w_rdy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap      <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_off       <= '0;
      r_cnt       <= '0;
      r_trunc     <= 1'b0;
      r_ovf       <= 1'b0;
      r_mem_write <= 1'b0;
      r_clken     <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_clken     <= 1'b1;
      r_mem_write <= w_pop;
      r_be        <= w_pop ? 4'hF : 4'h0;
      if (w_pop) begin
        r_addr  <= r_base + r_off;
        r_wdata <= w_fifo_dat;
        r_off   <= (r_wrap && (r_off == r_len - ADDR_W'(1))) ? '0 : r_off + ADDR_W'(1);
        if (r_cnt != r_len) r_cnt <= r_cnt + ADDR_W'(1);
      end
      if (w_push) begin
        r_acc <= r_acc + ADDR_W'(1);
        if (w_last && !snk_eop) r_trunc <= 1'b1;
      end
      // Truncated packet: the source still has beats to offer after the window closed.
      if ((r_state == ST_DRAIN || r_state == ST_DONE) && r_trunc && snk_valid) r_ovf <= 1'b1;
      if (w_start) begin
        r_wrap  <= cfg_wrap;
        r_base  <= cfg_base;
        r_len   <= cfg_len;
        r_acc   <= '0;
        r_off   <= '0;
        r_cnt   <= '0;
        r_trunc <= 1'b0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign mem_address    = r_addr;
  assign mem_byteenable = r_be;
  assign mem_chipselect = r_mem_write;
  assign mem_write      = r_mem_write;
  assign mem_writedata  = r_wdata;
  assign mem_clken      = r_clken;
  assign sts_overflow   = r_ovf;
  assign sts_count      = r_cnt;

endmodule

// File: tb/tb_rfs_wifi_sample_capture.sv
// Directed bench for the capture writer: one-shot, truncation, wrap, pre-sop junk, abort, reset.
module tb_rfs_wifi_sample_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic        cfg_wrap = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_len = '0;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_sop = 1'b0;
  logic        snk_eop = 1'b0;
  logic        snk_ready;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        sts_busy;
  logic        sts_done;
  logic        sts_overflow;
  logic [15:0] sts_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];

  rfs_wifi_sample_capture dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .cfg_wrap       (cfg_wrap),
    .cfg_base       (cfg_base),
    .cfg_len        (cfg_len),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .snk_ready      (snk_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .sts_busy       (sts_busy),
    .sts_done       (sts_done),
    .sts_overflow   (sts_overflow),
    .sts_count      (sts_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every bus cycle must be a full-word write; record it for later checks.
  always @(negedge clk) begin
    if (reset_n && (mem_write || mem_chipselect)) begin
      n_cmp++;
      assert ({mem_write, mem_chipselect, mem_byteenable} === 6'b11_1111) else begin
        n_err++;
        $error("FAIL bus_strobe: observed %b expected 111111",
               {mem_write, mem_chipselect, mem_byteenable});
      end
      q_addr.push_back(mem_address);
      q_data.push_back(mem_writedata);
    end
  end

  task automatic start(input logic [15:0] base, input logic [15:0] len, input logic wrap);
    cfg_base  = base;
    cfg_len   = len;
    cfg_wrap  = wrap;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic sop, input logic eop);
    bit acc = 1'b0;
    snk_data  = d;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      #1;
      acc = snk_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      seen = sts_done;
    end
    chk(tag, 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_one_cycle"}, {sts_done, sts_busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {snk_ready, mem_byteenable, mem_chipselect, mem_write, mem_clken,
                    sts_busy, sts_done, sts_overflow}, 32'd0);
    chk("rst_addr_cnt", {mem_address, sts_count}, 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("clken_on", mem_clken, 32'd1);

    // 1: one-shot, exact-length packet
    start(16'h0100, 16'd4, 1'b0);
    chk("t1_busy_ready", {sts_busy, snk_ready}, 32'd3);
    n0 = q_addr.size();
    send(32'hA000_0000, 1'b1, 1'b0);
    chk("t1_latency_idle", mem_write, 32'd0);
    send(32'hA000_0001, 1'b0, 1'b0);
    chk("t1_latency_write", {mem_write, mem_address}, {1'b1, 16'h0100});
    chk("t1_first_data", mem_writedata, 32'hA000_0000);
    send(32'hA000_0002, 1'b0, 1'b0);
    send(32'hA000_0003, 1'b0, 1'b1);
    idle();
    wait_done("t1_done");
    chk("t1_nwrites", q_addr.size() - n0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), q_addr[n0+i], 32'h0100 + i);
      chk($sformatf("t1_data%0d", i), q_data[n0+i], 32'hA000_0000 + i);
    end
    chk("t1_count", sts_count, 32'd4);
    chk("t1_ovf", sts_overflow, 32'd0);

    // 2: truncation of a 6-beat packet into a 3-word window
    start(16'h0200, 16'd3, 1'b0);
    n0 = q_addr.size();
    send(32'hB000_0000, 1'b1, 1'b0);
    send(32'hB000_0001, 1'b0, 1'b0);
    send(32'hB000_0002, 1'b0, 1'b0);
    snk_data = 32'hB000_0003;
    snk_sop  = 1'b0;
    snk_eop  = 1'b0;
    #1;
    chk("t2_ready_low", snk_ready, 32'd0);
    wait_done("t2_done");
    idle();
    chk("t2_nwrites", q_addr.size() - n0, 32'd3);
    chk("t2_addr_first", q_addr[n0], 32'h0200);
    chk("t2_addr_last", q_addr[n0+2], 32'h0202);
    chk("t2_data_last", q_data[n0+2], 32'hB000_0002);
    chk("t2_ovf", sts_overflow, 32'd1);
    chk("t2_count", sts_count, 32'd3);

    // 3: circular window overrun
    start(16'h8000, 16'd4, 1'b1);
    chk("t3_ovf_cleared", sts_overflow, 32'd0);
    n0 = q_addr.size();
    for (int i = 0; i < 10; i++) send(32'hC000_0000 + i, i == 0, i == 9);
    idle();
    wait_done("t3_done");
    chk("t3_nwrites", q_addr.size() - n0, 32'd10);
    chk("t3_addr3", q_addr[n0+3], 32'h8003);
    chk("t3_addr4_wrap", q_addr[n0+4], 32'h8000);
    chk("t3_addr_last", q_addr[n0+9], 32'h8001);
    chk("t3_data_last", q_data[n0+9], 32'hC000_0009);
    chk("t3_count_sat", sts_count, 32'd4);
    chk("t3_ovf", sts_overflow, 32'd0);

    // 4: non-sop beats before the packet are dropped
    start(16'h0300, 16'd8, 1'b0);
    n0 = q_addr.size();
    send(32'hEEEE_0000, 1'b0, 1'b0);
    send(32'hEEEE_0001, 1'b0, 1'b0);
    send(32'hEEEE_0002, 1'b0, 1'b0);
    send(32'hD000_0000, 1'b1, 1'b0);
    send(32'hD000_0001, 1'b0, 1'b1);
    idle();
    wait_done("t4_done");
    chk("t4_nwrites", q_addr.size() - n0, 32'd2);
    chk("t4_addr_first", q_addr[n0], 32'h0300);
    chk("t4_data_first", q_data[n0], 32'hD000_0000);
    chk("t4_data_second", q_data[n0+1], 32'hD000_0001);
    chk("t4_count", sts_count, 32'd2);

    // 5: abort after five writes, then a fresh capture
    start(16'h0400, 16'd16, 1'b0);
    n0 = q_addr.size();
    for (int i = 0; i < 6; i++) send(32'hE000_0000 + i, i == 0, 1'b0);
    cfg_abort = 1'b1;
    idle();
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    chk("t5_write_off", mem_write, 32'd0);
    chk("t5_idle", sts_busy, 32'd0);
    chk("t5_count_hold", sts_count, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | sts_done;
    end
    chk("t5_no_done", 32'(seen), 32'd0);
    chk("t5_nwrites", q_addr.size() - n0, 32'd5);
    start(16'h0500, 16'd2, 1'b0);
    n0 = q_addr.size();
    send(32'hF000_0000, 1'b1, 1'b0);
    send(32'hF000_0001, 1'b0, 1'b1);
    idle();
    wait_done("t5_restart_done");
    chk("t5_restart_nwrites", q_addr.size() - n0, 32'd2);
    chk("t5_restart_addr", q_addr[n0], 32'h0500);
    chk("t5_restart_data", q_data[n0], 32'hF000_0000);

    // 6: asynchronous reset mid-capture, then a zero-length start
    start(16'h0600, 16'd8, 1'b0);
    send(32'h1111_0000, 1'b1, 1'b0);
    send(32'h1111_0001, 1'b0, 1'b0);
    send(32'h1111_0002, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {snk_ready, mem_byteenable, mem_chipselect, mem_write, mem_clken,
                       sts_busy, sts_done, sts_overflow}, 32'd0);
    chk("t6_rst_addr_cnt", {mem_address, sts_count}, 32'd0);
    chk("t6_rst_wdata", mem_writedata, 32'd0);
    idle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    n0 = q_addr.size();
    @(posedge clk); #1;
    chk("t6_clken", {mem_clken, sts_busy}, 32'd2);
    start(16'h0700, 16'd0, 1'b0);
    chk("t6_len0_done", sts_done, 32'd1);
    @(posedge clk); #1;
    chk("t6_len0_idle", {sts_done, sts_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_len0_nwrites", q_addr.size() - n0, 32'd0);
    chk("t6_len0_count", sts_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
